// File: rtl/faiz_pkg.sv
// Shared definitions for the faiz (interest-rate) blocks.
//   FAIZ_W   : width of every rate value
//   durum_t  : announcement FSM states (BEKLE / SAYIM / ILAN)
//   YON_*    : announcement direction codes
package faiz_pkg;

    localparam int FAIZ_W = 6;

    typedef enum logic [1:0] {
        BEKLE = 2'd0,
        SAYIM = 2'd1,
        ILAN  = 2'd2
    } durum_t;

    localparam logic [1:0] YON_YOK = 2'b00;
    localparam logic [1:0] YON_ART = 2'b01;
    localparam logic [1:0] YON_AZ  = 2'b10;

endpackage

// File: rtl/faiz_adim_sinirla.sv
// Step limiter: moves from the current policy rate towards the candidate by at
// most ADIM, and reports the direction of the move.
//   politika : current policy rate
//   aday     : candidate rate to approach
//   hedef    : step-limited target (always between politika and aday)
//   yon      : YON_ART / YON_AZ / YON_YOK
module faiz_adim_sinirla
    import faiz_pkg::*;
#(
    parameter int ADIM = 5
) (
    input  logic [FAIZ_W-1:0] politika,
    input  logic [FAIZ_W-1:0] aday,
    output logic [FAIZ_W-1:0] hedef,
    output logic [1:0]        yon
);

    localparam logic signed [FAIZ_W:0] ADIM_S = (FAIZ_W+1)'(ADIM);
    localparam logic [FAIZ_W-1:0]      ADIM_U = FAIZ_W'(ADIM);

    logic signed [FAIZ_W:0] fark;

    always_comb begin
        fark  = $signed({1'b0, aday}) - $signed({1'b0, politika});
        hedef = aday;
        yon   = YON_YOK;
        // The clipped target lies strictly between politika and aday, so the
        // 6-bit add/subtract cannot wrap.
        if (fark > ADIM_S) begin
            hedef = politika + ADIM_U;
        end else if (fark < -ADIM_S) begin
            hedef = politika - ADIM_U;
        end
        if (fark > 0) begin
            yon = YON_ART;
        end else if (fark < 0) begin
            yon = YON_AZ;
        end
    end

endmodule

// File: rtl/faiz_ilan.sv
// Rate announcement stage: debounces the sampled faiz stream, offers a
// step-limited announcement on a valid/ready handshake and counts transfers.
//   saat / reset   : clock, asynchronous active-high reset
//   faiz           : incoming rate, sampled every rising edge
//   ilan_hazir     : downstream ready
//   ilan_gecerli   : announcement valid
//   ilan_faiz      : announced (step-limited) rate
//   ilan_yon       : 00 none, 01 increase, 10 decrease
//   politika_faiz  : last accepted announced rate
//   ilan_sayisi    : accepted announcements, saturating
module faiz_ilan
    import faiz_pkg::*;
#(
    parameter int STABIL  = 3,
    parameter int ADIM    = 5,
    parameter int SAYAC_W = 8
) (
    input  logic               saat,
    input  logic               reset,
    input  logic [FAIZ_W-1:0]  faiz,
    input  logic               ilan_hazir,
    output logic               ilan_gecerli,
    output logic [FAIZ_W-1:0]  ilan_faiz,
    output logic [1:0]         ilan_yon,
    output logic [FAIZ_W-1:0]  politika_faiz,
    output logic [SAYAC_W-1:0] ilan_sayisi
);

    localparam int              SW       = $clog2(STABIL + 1);
    localparam logic [SW-1:0]   STABIL_C = SW'(STABIL);

    durum_t              state_q, state_d;
    logic [FAIZ_W-1:0]   aday_q, aday_d;
    logic [SW-1:0]       sayac_q, sayac_d;
    logic                gecerli_q, gecerli_d;
    logic [FAIZ_W-1:0]   ilan_faiz_q, ilan_faiz_d;
    logic [1:0]          yon_q, yon_d;
    logic [FAIZ_W-1:0]   politika_q, politika_d;
    logic [SAYAC_W-1:0]  sayisi_q, sayisi_d;

    logic                yukle;
    logic [FAIZ_W-1:0]   hedef;
    logic [1:0]          hedef_yon;

    function automatic logic [SAYAC_W-1:0] doyur_artir(input logic [SAYAC_W-1:0] x);
        return (&x) ? x : x + SAYAC_W'(1);
    endfunction

    // Whenever an announcement is loaded the current sample equals the
    // candidate, so the limiter can look at faiz directly and stay free of the
    // next-state logic.
    faiz_adim_sinirla #(
        .ADIM (ADIM)
    ) u_sinirla (
        .politika (politika_q),
        .aday     (faiz),
        .hedef    (hedef),
        .yon      (hedef_yon)
    );

    always_comb begin
        state_d     = state_q;
        aday_d      = aday_q;
        sayac_d     = sayac_q;
        gecerli_d   = gecerli_q;
        ilan_faiz_d = ilan_faiz_q;
        yon_d       = yon_q;
        politika_d  = politika_q;
        sayisi_d    = sayisi_q;
        yukle       = 1'b0;

        case (state_q)
            BEKLE: begin
                if (faiz != politika_q) begin
                    aday_d  = faiz;
                    sayac_d = SW'(1);
                    if (STABIL == 1) yukle   = 1'b1;
                    else             state_d = SAYIM;
                end
            end
            SAYIM: begin
                if (faiz != aday_q) begin
                    aday_d  = faiz;
                    sayac_d = SW'(1);
                    if (faiz == politika_q) state_d = BEKLE;
                end else begin
                    sayac_d = sayac_q + SW'(1);
                    if (sayac_d == STABIL_C) yukle = 1'b1;
                end
            end
            ILAN: begin
                // faiz is ignored here; only the handshake moves us on.
                if (ilan_hazir) begin
                    politika_d = ilan_faiz_q;
                    sayisi_d   = doyur_artir(sayisi_q);
                    gecerli_d  = 1'b0;
                    yon_d      = YON_YOK;
                    state_d    = BEKLE;
                end
            end
            default: state_d = BEKLE;
        endcase

        if (yukle) begin
            state_d     = ILAN;
            ilan_faiz_d = hedef;
            yon_d       = hedef_yon;
            gecerli_d   = 1'b1;
        end
    end

    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            state_q     <= BEKLE;
            aday_q      <= '0;
            sayac_q     <= '0;
            gecerli_q   <= 1'b0;
            ilan_faiz_q <= '0;
            yon_q       <= YON_YOK;
            politika_q  <= '0;
            sayisi_q    <= '0;
        end else begin
            state_q     <= state_d;
            aday_q      <= aday_d;
            sayac_q     <= sayac_d;
            gecerli_q   <= gecerli_d;
            ilan_faiz_q <= ilan_faiz_d;
            yon_q       <= yon_d;
            politika_q  <= politika_d;
            sayisi_q    <= sayisi_d;
        end
    end

    assign ilan_gecerli  = gecerli_q;
    assign ilan_faiz     = ilan_faiz_q;
    assign ilan_yon      = yon_q;
    assign politika_faiz = politika_q;
    assign ilan_sayisi   = sayisi_q;

endmodule

// File: tb/tb_faiz_ilan.sv
module tb_faiz_ilan;

    logic saat = 1'b0;
    logic reset;

    // Instance A: STABIL=3, ADIM=5, SAYAC_W=8
    logic [5:0] a_faiz, a_ilan_faiz, a_politika;
    logic       a_hazir, a_gec;
    logic [1:0] a_yon;
    logic [7:0] a_sayisi;

    // Instance B: STABIL=3, ADIM=5, SAYAC_W=2
    logic [5:0] b_faiz, b_ilan_faiz, b_politika;
    logic       b_hazir, b_gec;
    logic [1:0] b_yon;
    logic [1:0] b_sayisi;

    // Instance C: STABIL=1, ADIM=5, SAYAC_W=8
    logic [5:0] c_faiz, c_ilan_faiz, c_politika;
    logic       c_hazir, c_gec;
    logic [1:0] c_yon;
    logic [7:0] c_sayisi;

    int vektor_sayisi = 0;
    int hata_sayisi   = 0;

    always #5 saat = ~saat;

    faiz_ilan #(.STABIL(3), .ADIM(5), .SAYAC_W(8)) dut_a (
        .saat (saat), .reset (reset), .faiz (a_faiz), .ilan_hazir (a_hazir),
        .ilan_gecerli (a_gec), .ilan_faiz (a_ilan_faiz), .ilan_yon (a_yon),
        .politika_faiz (a_politika), .ilan_sayisi (a_sayisi)
    );

    faiz_ilan #(.STABIL(3), .ADIM(5), .SAYAC_W(2)) dut_b (
        .saat (saat), .reset (reset), .faiz (b_faiz), .ilan_hazir (b_hazir),
        .ilan_gecerli (b_gec), .ilan_faiz (b_ilan_faiz), .ilan_yon (b_yon),
        .politika_faiz (b_politika), .ilan_sayisi (b_sayisi)
    );

    faiz_ilan #(.STABIL(1), .ADIM(5), .SAYAC_W(8)) dut_c (
        .saat (saat), .reset (reset), .faiz (c_faiz), .ilan_hazir (c_hazir),
        .ilan_gecerli (c_gec), .ilan_faiz (c_ilan_faiz), .ilan_yon (c_yon),
        .politika_faiz (c_politika), .ilan_sayisi (c_sayisi)
    );

    task automatic kontrol(input string etiket, input int gozlenen, input int beklenen);
        vektor_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: got %0d expected %0d", etiket, gozlenen, beklenen);
        end
    endtask

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic kenar();
        @(posedge saat);
        @(negedge saat);
    endtask

    task automatic bekle_a(output int n);
        n = 0;
        do begin
            kenar();
            n++;
        end while (!a_gec && n < 20);
    endtask

    task automatic bekle_b(output int n);
        n = 0;
        do begin
            kenar();
            n++;
        end while (!b_gec && n < 20);
    endtask

    initial begin
        int n;
        int goruldu;
        int adim_hedef[3] = '{5, 10, 12};

        reset   = 1'b1;
        a_faiz  = '0; a_hazir = 1'b0;
        b_faiz  = '0; b_hazir = 1'b1;
        c_faiz  = '0; c_hazir = 1'b0;
        repeat (2) @(negedge saat);
        kontrol("rst_gec",    a_gec, 0);
        kontrol("rst_faiz",   a_ilan_faiz, 0);
        kontrol("rst_yon",    a_yon, 0);
        reset = 1'b0;

        // 1: idle input equal to policy rate
        goruldu = 0;
        repeat (10) begin
            kenar();
            if (a_gec) goruldu = 1;
        end
        kontrol("t1_gec",      goruldu, 0);
        kontrol("t1_politika", a_politika, 0);
        kontrol("t1_sayisi",   a_sayisi, 0);

        // 2: staircase 0 -> 5 -> 10 -> 12
        a_faiz  = 6'd12;
        a_hazir = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bekle_a(n);
            kontrol("t2_gecikme", n, 3);
            kontrol("t2_ilan",    a_ilan_faiz, adim_hedef[k]);
            kontrol("t2_yon",     a_yon, 1);
            kenar();
            kontrol("t2_gec_dus", a_gec, 0);
            kontrol("t2_politika", a_politika, adim_hedef[k]);
        end
        kontrol("t2_sayisi", a_sayisi, 3);

        // 3: glitch shorter than the debounce window
        a_faiz  = 6'd14;
        goruldu = 0;
        repeat (2) begin
            kenar();
            if (a_gec) goruldu = 1;
        end
        a_faiz = 6'd12;
        repeat (6) begin
            kenar();
            if (a_gec) goruldu = 1;
        end
        kontrol("t3_gec",      goruldu, 0);
        kontrol("t3_sayisi",   a_sayisi, 3);
        kontrol("t3_politika", a_politika, 12);

        // 4: decrease within step, held with ready low, faiz ignored while held
        a_faiz  = 6'd9;
        a_hazir = 1'b0;
        bekle_a(n);
        kontrol("t4_gecikme", n, 3);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) a_faiz = 6'd40;
            kontrol("t4_tut", {a_gec, a_ilan_faiz, a_yon}, {1'b1, 6'd9, 2'b10});
            kenar();
        end
        kontrol("t4_politika_tut", a_politika, 12);
        a_hazir = 1'b1;
        kenar();
        kontrol("t4_politika", a_politika, 9);
        kontrol("t4_gec_dus",  a_gec, 0);
        kontrol("t4_sayisi",   a_sayisi, 4);
        kontrol("t4_ilan_kal", a_ilan_faiz, 9);

        // 5: asynchronous reset while an announcement is pending
        a_faiz  = 6'd20;
        a_hazir = 1'b0;
        bekle_a(n);
        kontrol("t5_gec",  a_gec, 1);
        kontrol("t5_ilan", a_ilan_faiz, 14);
        #2 reset = 1'b1;
        #1;
        kontrol("t5_rst_gec",      a_gec, 0);
        kontrol("t5_rst_ilan",     a_ilan_faiz, 0);
        kontrol("t5_rst_yon",      a_yon, 0);
        kontrol("t5_rst_politika", a_politika, 0);
        kontrol("t5_rst_sayisi",   a_sayisi, 0);
        @(negedge saat);
        a_faiz = '0;
        reset  = 1'b0;

        // 6a: narrow counter saturates at 3 after 5 transfers
        b_faiz = 6'd3;
        for (int i = 0; i < 5; i++) begin
            bekle_b(n);
            kontrol("t6_gecikme", n, 3);
            kenar();
            kontrol("t6_sayisi", b_sayisi, (i + 1 > 3) ? 3 : i + 1);
            b_faiz = (b_faiz == 6'd3) ? 6'd0 : 6'd3;
        end

        // 6b: STABIL=1 announces after a single edge
        c_faiz = 6'd2;
        kenar();
        kontrol("t6_s1_gec",  c_gec, 1);
        kontrol("t6_s1_ilan", c_ilan_faiz, 2);
        kontrol("t6_s1_yon",  c_yon, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vektor_sayisi, hata_sayisi);
        $finish;
    end

endmodule
